// File: rtl/ifetch_stage_pkg.sv
// ifetch_stage_pkg: shared widths, reset/NOP constants and fetch FSM states
package ifetch_stage_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_RESET = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int IFID_W = 1 + 32 + 2 * XLEN;
  localparam logic [IFID_W-1:0] IFID_BUBBLE = {1'b0, NOP_INSTR, {(2 * XLEN){1'b0}}};
  typedef enum logic [1:0] {S_BOOT, S_REQ, S_HOLD} state_t;
endpackage

// File: rtl/ifetch_stage_pipe_reg_sf.sv
// pipe_reg_sf: pipeline register with enable and a flush that loads FLUSH_VAL
module pipe_reg_sf #(
  parameter int W = 1,
  parameter logic [W-1:0] FLUSH_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) q <= (reset || flush) ? FLUSH_VAL : en ? d : q;
endmodule

// File: rtl/ifetch_stage.sv
// ifetch_stage: PC, imem handshake, pending redirect, skid buffer and IF/ID register
module ifetch_stage
  import ifetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rdy,
  input  logic [31:0]     imem_rdata,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
);
  state_t state, state_n;
  logic [XLEN-1:0] pc, pc_n, pc_plus4, pend_tgt, pend_tgt_n, skid_pc, skid_pc_n;
  logic [31:0] skid_instr, skid_instr_n;
  logic pend_vld, pend_vld_n, skid_vld, skid_vld_n;
  logic [IFID_W-1:0] ifid_d, ifid_q;
  assign pc_plus4 = pc + XLEN'(4);
  assign imem_addr = pc;
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_BOOT;
      pc <= PC_RESET;
      pend_vld <= 1'b0;
      pend_tgt <= '0;
      skid_vld <= 1'b0;
      skid_pc <= '0;
      skid_instr <= NOP_INSTR;
    end else begin
      state <= state_n;
      pc <= pc_n;
      pend_vld <= pend_vld_n;
      pend_tgt <= pend_tgt_n;
      skid_vld <= skid_vld_n;
      skid_pc <= skid_pc_n;
      skid_instr <= skid_instr_n;
    end
  always_comb begin
    state_n = state;
    pc_n = pc;
    pend_vld_n = pend_vld;
    pend_tgt_n = pend_tgt;
    skid_vld_n = skid_vld;
    skid_pc_n = skid_pc;
    skid_instr_n = skid_instr;
    ifid_d = IFID_BUBBLE;
    imem_req = 1'b0;
    case (state)
      S_BOOT: begin
        state_n = S_REQ;
        pc_n = redirect ? redirect_target : pc;
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (!imem_rdy) begin
          pend_vld_n = pend_vld || redirect;
          pend_tgt_n = redirect ? redirect_target : pend_tgt;
        end else if (redirect || pend_vld) begin
          // wrong-path word: drop it, the newest redirect target wins
          pc_n = redirect ? redirect_target : pend_tgt;
          pend_vld_n = 1'b0;
        end else if (stall) begin
          skid_vld_n = 1'b1;
          skid_pc_n = pc;
          skid_instr_n = imem_rdata;
          pc_n = pc_plus4;
          state_n = S_HOLD;
        end else begin
          ifid_d = {1'b1, imem_rdata, pc, pc_plus4};
          pc_n = pc_plus4;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          skid_vld_n = 1'b0;
          pc_n = redirect_target;
          state_n = S_REQ;
        end else if (!stall) begin
          ifid_d = {skid_vld, skid_instr, skid_pc, skid_pc + XLEN'(4)};
          skid_vld_n = 1'b0;
          state_n = S_REQ;
        end
      end
      default: state_n = S_BOOT;
    endcase
  end
  pipe_reg_sf #(.W(IFID_W), .FLUSH_VAL(IFID_BUBBLE)) u_ifid (
    .clk(clk), .reset(reset), .en(!stall), .flush(redirect), .d(ifid_d), .q(ifid_q)
  );
  assign {id_valid, id_instr, id_pc, id_pc_plus4} = ifid_q;
endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: directed scenario tests for the fetch stage
module tb_ifetch_stage;
  logic clk = 0, reset, stall, redirect, imem_req, imem_rdy, id_valid;
  logic [31:0] redirect_target, imem_addr, imem_rdata, id_instr, id_pc, id_pc_plus4;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};
  ifetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdy(imem_rdy), .imem_rdata(imem_rdata), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset = 1; stall = 0; redirect = 0; redirect_target = 0; imem_rdy = 0;
    step(); step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", id_valid); end
    checks++; if (id_instr !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h exp 00000013", id_instr); end
    checks++; if ({id_pc, id_pc_plus4} !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h/%h exp 0/0", id_pc, id_pc_plus4); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", imem_req); end
  endtask
  task automatic test_straight();
    reset = 0; imem_rdy = 1;
    step();
    checks++; if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'h0, 1'b0}) begin errors++; $display("FAIL boot_req: got req %b addr %h valid %b exp 1 0 0", imem_req, imem_addr, id_valid); end
    step();
    checks++; if ({id_valid, id_pc, id_instr, id_pc_plus4} !== {1'b1, 32'h0, 32'hC0DE0000, 32'h4}) begin errors++; $display("FAIL straight0: got %b %h %h %h exp 1 0 c0de0000 4", id_valid, id_pc, id_instr, id_pc_plus4); end
    step();
    checks++; if ({id_valid, id_pc, imem_addr} !== {1'b1, 32'h4, 32'h8}) begin errors++; $display("FAIL straight4: got %b %h addr %h exp 1 4 8", id_valid, id_pc, imem_addr); end
  endtask
  task automatic test_wait_states();
    imem_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'h8, 1'b0}) begin errors++; $display("FAIL wait%0d: got req %b addr %h valid %b exp 1 8 0", i, imem_req, imem_addr, id_valid); end
    end
    imem_rdy = 1;
    step();
    checks++; if ({id_valid, id_pc, id_instr, imem_addr} !== {1'b1, 32'h8, 32'hC0DE0008, 32'hC}) begin errors++; $display("FAIL wait_done: got %b %h %h addr %h exp 1 8 c0de0008 c", id_valid, id_pc, id_instr, imem_addr); end
  endtask
  task automatic test_stall();
    stall = 1;
    step();
    checks++; if ({imem_req, id_valid, id_pc, id_instr} !== {1'b0, 1'b1, 32'h8, 32'hC0DE0008}) begin errors++; $display("FAIL stall_hold: got req %b %b %h %h exp 0 1 8 c0de0008", imem_req, id_valid, id_pc, id_instr); end
    step();
    checks++; if ({imem_req, id_pc} !== {1'b0, 32'h8}) begin errors++; $display("FAIL stall_hold2: got req %b pc %h exp 0 8", imem_req, id_pc); end
    stall = 0;
    step();
    checks++; if ({id_valid, id_pc, id_instr, imem_req, imem_addr} !== {1'b1, 32'hC, 32'hC0DE000C, 1'b1, 32'h10}) begin errors++; $display("FAIL stall_release: got %b %h %h req %b addr %h exp 1 c c0de000c 1 10", id_valid, id_pc, id_instr, imem_req, imem_addr); end
    step();
    checks++; if ({id_valid, id_pc, imem_addr} !== {1'b1, 32'h10, 32'h14}) begin errors++; $display("FAIL after_stall: got %b %h addr %h exp 1 10 14", id_valid, id_pc, imem_addr); end
  endtask
  task automatic test_redirect_wait();
    imem_rdy = 0;
    step();
    redirect = 1; redirect_target = 32'h100;
    step();
    checks++; if ({imem_addr, id_valid} !== {32'h14, 1'b0}) begin errors++; $display("FAIL rw_pending: got addr %h valid %b exp 14 0", imem_addr, id_valid); end
    redirect = 0;
    step();
    imem_rdy = 1;
    step();
    checks++; if ({id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin errors++; $display("FAIL rw_discard: got valid %b req %b addr %h exp 0 1 100", id_valid, imem_req, imem_addr); end
    step();
    checks++; if ({id_valid, id_pc, imem_addr} !== {1'b1, 32'h100, 32'h104}) begin errors++; $display("FAIL rw_target: got %b %h addr %h exp 1 100 104", id_valid, id_pc, imem_addr); end
  endtask
  task automatic test_redirect_stall();
    stall = 1; redirect = 1; redirect_target = 32'h200;
    step();
    checks++; if ({id_valid, id_instr, imem_req, imem_addr} !== {1'b0, 32'h13, 1'b1, 32'h200}) begin errors++; $display("FAIL rs_flush: got %b %h req %b addr %h exp 0 00000013 1 200", id_valid, id_instr, imem_req, imem_addr); end
    stall = 0; redirect = 0;
    step();
    checks++; if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h200, 32'hC0DE0200}) begin errors++; $display("FAIL rs_next: got %b %h %h exp 1 200 c0de0200", id_valid, id_pc, id_instr); end
  endtask
  task automatic test_pend_override();
    imem_rdy = 0; redirect = 1; redirect_target = 32'h300;
    step();
    imem_rdy = 1; redirect_target = 32'h400;
    step();
    checks++; if ({id_valid, imem_addr} !== {1'b0, 32'h400}) begin errors++; $display("FAIL po_addr: got valid %b addr %h exp 0 400", id_valid, imem_addr); end
    redirect = 0;
    step();
    checks++; if ({id_valid, id_pc} !== {1'b1, 32'h400}) begin errors++; $display("FAIL po_id: got %b %h exp 1 400", id_valid, id_pc); end
  endtask
  task automatic test_wrap();
    redirect = 1; redirect_target = 32'hFFFF_FFFC;
    step();
    redirect = 0;
    step();
    checks++; if ({id_valid, id_pc, id_pc_plus4, imem_addr} !== {1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0}) begin errors++; $display("FAIL wrap: got %b %h %h addr %h exp 1 fffffffc 0 0", id_valid, id_pc, id_pc_plus4, imem_addr); end
  endtask
  task automatic test_hold_redirect();
    stall = 1;
    step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hr_hold: got req %b exp 0", imem_req); end
    redirect = 1; redirect_target = 32'h500;
    step();
    checks++; if ({id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h500}) begin errors++; $display("FAIL hr_redirect: got valid %b req %b addr %h exp 0 1 500", id_valid, imem_req, imem_addr); end
    redirect = 0; stall = 0;
    step();
    checks++; if ({id_valid, id_pc} !== {1'b1, 32'h500}) begin errors++; $display("FAIL hr_next: got %b %h exp 1 500", id_valid, id_pc); end
  endtask
  task automatic test_reset_mid();
    imem_rdy = 0;
    step();
    reset = 1;
    step();
    checks++; if ({id_valid, id_instr, id_pc, id_pc_plus4, imem_req, imem_addr} !== {1'b0, 32'h13, 64'h0, 1'b0, 32'h0}) begin errors++; $display("FAIL rm_reset: got %b %h %h %h req %b addr %h exp 0 13 0 0 0 0", id_valid, id_instr, id_pc, id_pc_plus4, imem_req, imem_addr); end
    reset = 0; imem_rdy = 1;
    step();
    checks++; if ({id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h0}) begin errors++; $display("FAIL rm_boot: got valid %b req %b addr %h exp 0 1 0", id_valid, imem_req, imem_addr); end
    step();
    checks++; if ({id_valid, id_pc, imem_addr} !== {1'b1, 32'h0, 32'h4}) begin errors++; $display("FAIL rm_first: got %b %h addr %h exp 1 0 4", id_valid, id_pc, imem_addr); end
  endtask
  initial begin
    test_reset();
    test_straight();
    test_wait_states();
    test_stall();
    test_redirect_wait();
    test_redirect_stall();
    test_pend_override();
    test_wrap();
    test_hold_redirect();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
